// File: rtl/apb_decode_n.sv
// APB 1-to-N decoder with registered request/response path,
// unmapped-address error response and per-access downstream timeout.
module apb_decode_n #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int IDX_LSB        = 12,
   parameter int IDX_W          = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_psel,
   input  logic                         s_penable,
   input  logic                         s_pwrite,
   input  logic [ADDR_W-1:0]            s_paddr,
   input  logic [DATA_W-1:0]            s_pwdata,
   output logic [DATA_W-1:0]            s_prdata,
   output logic                         s_pready,
   output logic                         s_pslverr,
   output logic [NUM_SLAVES-1:0]        m_psel,
   output logic                         m_penable,
   output logic                         m_pwrite,
   output logic [ADDR_W-1:0]            m_paddr,
   output logic [DATA_W-1:0]            m_pwdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] m_prdata,
   input  logic [NUM_SLAVES-1:0]        m_pready,
   input  logic [NUM_SLAVES-1:0]        m_pslverr,
   output logic                         err_decode,
   output logic                         err_timeout
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam int CNT_W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   logic [1:0]            state;
   logic [IDX_W-1:0]      idx_q;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx_in;
   logic                  hit_in;
   logic [NUM_SLAVES-1:0] in_oh;
   logic [DATA_W-1:0]     sel_rdata;
   logic                  sel_rdy;
   logic                  sel_err;
   logic                  to_hit;

   assign idx_in = s_paddr[IDX_LSB +: IDX_W];
   assign hit_in = (int'(idx_in) < NUM_SLAVES);
   assign to_hit = TO_EN && (cnt == CNT_LAST);

   // Decode the incoming index and mux the selected slave's response
   always_comb begin
      in_oh     = '0;
      sel_rdata = '0;
      sel_rdy   = 1'b0;
      sel_err   = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         in_oh[i] = (idx_in == IDX_W'(i));
         if (idx_q == IDX_W'(i)) begin
            sel_rdata = m_prdata[i*DATA_W +: DATA_W];
            sel_rdy   = m_pready[i];
            sel_err   = m_pslverr[i];
         end
      end
   end

   // Transfer FSM; every upstream and downstream output is a flop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx_q       <= '0;
         cnt         <= '0;
         s_prdata    <= '0;
         s_pready    <= 1'b0;
         s_pslverr   <= 1'b0;
         m_psel      <= '0;
         m_penable   <= 1'b0;
         m_pwrite    <= 1'b0;
         m_paddr     <= '0;
         m_pwdata    <= '0;
         err_decode  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_decode  <= 1'b0;
         err_timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (s_psel && !s_penable) begin
                  m_paddr  <= s_paddr;
                  m_pwrite <= s_pwrite;
                  m_pwdata <= s_pwdata;
                  idx_q    <= idx_in;
                  if (hit_in) begin
                     m_psel <= in_oh;
                     state  <= SETUP;
                  end else begin
                     s_pready   <= 1'b1;
                     s_pslverr  <= 1'b1;
                     s_prdata   <= '0;
                     err_decode <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            SETUP: begin
               m_penable <= 1'b1;
               cnt       <= '0;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (sel_rdy) begin
                  m_psel    <= '0;
                  m_penable <= 1'b0;
                  s_pready  <= 1'b1;
                  s_prdata  <= sel_rdata;
                  s_pslverr <= sel_err;
                  state     <= RESP;
               end else if (to_hit) begin
                  m_psel      <= '0;
                  m_penable   <= 1'b0;
                  s_pready    <= 1'b1;
                  s_prdata    <= '0;
                  s_pslverr   <= 1'b1;
                  err_timeout <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               s_pready  <= 1'b0;
               s_prdata  <= '0;
               s_pslverr <= 1'b0;
               cnt       <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_decode_n.sv
// Bench for apb_decode_n: directed cases plus random transfers
// checked against a latency/response model of the decoder.
module tb_apb_decode_n;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_psel;
   logic              s_penable;
   logic              s_pwrite;
   logic [AW-1:0]     s_paddr;
   logic [DW-1:0]     s_pwdata;
   logic [DW-1:0]     s_prdata;
   logic              s_pready;
   logic              s_pslverr;
   logic [NS-1:0]     m_psel;
   logic              m_penable;
   logic              m_pwrite;
   logic [AW-1:0]     m_paddr;
   logic [DW-1:0]     m_pwdata;
   logic [NS*DW-1:0]  m_prdata;
   logic [NS-1:0]     m_pready;
   logic [NS-1:0]     m_pslverr;
   logic              err_decode;
   logic              err_timeout;

   int checks = 0;
   int errors = 0;
   int tgt    = -1;
   int waits  = 0;
   int acc    = 0;
   logic [NS-1:0] oth_rdy = '0;

   always #5 clk = ~clk;

   apb_decode_n #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS),
      .IDX_LSB(12), .IDX_W(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_psel(s_psel), .s_penable(s_penable),
      .s_pwrite(s_pwrite), .s_paddr(s_paddr),
      .s_pwdata(s_pwdata), .s_prdata(s_prdata),
      .s_pready(s_pready), .s_pslverr(s_pslverr),
      .m_psel(m_psel), .m_penable(m_penable),
      .m_pwrite(m_pwrite), .m_paddr(m_paddr),
      .m_pwdata(m_pwdata), .m_prdata(m_prdata),
      .m_pready(m_pready), .m_pslverr(m_pslverr),
      .err_decode(err_decode), .err_timeout(err_timeout)
   );

   // Slave model: count enabled access cycles of the current transfer
   always @(posedge clk) begin
      if (m_penable && (m_psel != '0)) acc <= acc + 1;
      else acc <= 0;
   end

   // Target answers after `waits` wait states; others show random noise
   always_comb begin
      m_pready = '0;
      for (int i = 0; i < NS; i++) begin
         if (i == tgt)
            m_pready[i] = m_psel[i] && m_penable && (acc >= waits);
         else
            m_pready[i] = oth_rdy[i];
      end
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One upstream transfer; entered and left just after a rising edge
   task automatic xfer(input logic [AW-1:0] addr,
                       input logic wr,
                       input logic [DW-1:0] wd,
                       input int w,
                       input logic [DW-1:0] rd,
                       input logic se,
                       input string tag);
      int idx, exp_lat, exp_pen, lat, pen, sel_at;
      bit mapped, timed, bad, seen;
      logic [DW-1:0] exp_data, got_data;
      logic exp_err, got_err, got_de, got_dt;
      logic [AW-1:0] got_addr;
      logic [DW-1:0] got_wd;
      logic got_wr;
      logic [NS-1:0] exp_oh;
      idx      = int'((addr >> 12) & 32'hF);
      mapped   = idx < NS;
      timed    = mapped && (w >= TO);
      exp_lat  = !mapped ? 1 : (timed ? TO + 2 : w + 3);
      exp_pen  = !mapped ? 0 : (timed ? TO : w + 1);
      exp_data = (!mapped || timed) ? '0 : rd;
      exp_err  = !mapped || timed || se;
      exp_oh   = mapped ? NS'(1) << idx : '0;
      tgt      = mapped ? idx : -1;
      waits    = w;
      oth_rdy  = NS'($urandom);
      m_pslverr = NS'($urandom);
      for (int i = 0; i < NS; i++) m_prdata[i*DW +: DW] = $urandom;
      if (mapped) begin
         m_pslverr[idx] = se;
         m_prdata[idx*DW +: DW] = rd;
      end
      s_psel    = 1'b1;
      s_penable = 1'b0;
      s_paddr   = addr;
      s_pwrite  = wr;
      s_pwdata  = wd;
      @(posedge clk); #1;
      s_penable = 1'b1;
      lat = 0; pen = 0; sel_at = 0; bad = 0; seen = 0;
      got_data = '0; got_err = 0; got_de = 0; got_dt = 0;
      got_addr = '0; got_wd = '0; got_wr = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if ((m_psel & ~exp_oh) != '0) bad = 1;
         if (m_penable && (m_psel == '0)) bad = 1;
         if (m_penable) pen++;
         if ((m_psel != '0) && !seen) begin
            seen = 1; sel_at = n;
            got_addr = m_paddr; got_wd = m_pwdata; got_wr = m_pwrite;
         end
         if (s_pready) begin
            lat = n; got_data = s_prdata; got_err = s_pslverr;
            got_de = err_decode; got_dt = err_timeout;
            break;
         end
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " prdata"}, got_data, exp_data);
      chk({tag, " pslverr"}, got_err, exp_err);
      chk({tag, " err_decode"}, got_de, !mapped);
      chk({tag, " err_timeout"}, got_dt, timed);
      chk({tag, " penable_cycles"}, pen, exp_pen);
      chk({tag, " bad_select"}, bad, 0);
      if (mapped) begin
         chk({tag, " psel_at"}, sel_at, 1);
         chk({tag, " paddr"}, got_addr, addr);
         chk({tag, " pwdata"}, got_wd, wd);
         chk({tag, " pwrite"}, got_wr, wr);
      end else begin
         chk({tag, " no_psel"}, seen, 0);
      end
      @(posedge clk); #1;
      s_psel    = 1'b0;
      s_penable = 1'b0;
      tgt       = -1;
      @(negedge clk);
      chk({tag, " pready_drop"}, s_pready, 0);
      chk({tag, " errs_drop"}, {err_decode, err_timeout}, 0);
      chk({tag, " prdata_idle"}, s_prdata, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [AW-1:0] a;
      int w, idx;
      bit stale;
      rst_n     = 1'b0;
      s_psel    = 1'b0;
      s_penable = 1'b0;
      s_pwrite  = 1'b0;
      s_paddr   = '0;
      s_pwdata  = '0;
      m_prdata  = '0;
      m_pslverr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset m_psel", m_psel, 0);
      chk("reset m_penable", m_penable, 0);
      chk("reset s_pready", s_pready, 0);
      chk("reset s_prdata", s_prdata, 0);
      chk("reset errs", {s_pslverr, err_decode, err_timeout}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      xfer(32'h0000_1010, 1, 32'hA5A5_0001, 0, 32'h1111_2222, 0, "wr_s1");
      xfer(32'h0000_3004, 0, 32'h0, 5, 32'hDEAD_BEEF, 0, "rd_s3_w5");
      xfer(32'h0000_5000, 0, 32'h0, 0, 32'h1234_5678, 0, "unmapped5");
      xfer(32'h0000_2000, 0, 32'h0, 1000, 32'h5555_AAAA, 0, "timeout_s2");
      xfer(32'h0000_0008, 0, 32'h0, 0, 32'hCAFE_0000, 0, "after_to_s0");
      xfer(32'h0000_0100, 1, 32'h0BAD_0BAD, 2, 32'h0, 1, "wr_s0_err");
      xfer(32'h0000_2010, 0, 32'h0, TO - 1, 32'h7777_0007, 0, "edge_w7");
      xfer(32'h0000_F000, 1, 32'h1, 0, 32'h0, 0, "unmapped15");
      xfer(32'hFFFF_0FFC, 0, 32'h0, 1, 32'h0F0F_F0F0, 0, "hi_bits_s0");

      // Reset pulse while a transfer sits in ACCESS
      tgt = 2; waits = 1000;
      s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h0000_2000;
      s_pwrite = 1'b0;
      @(posedge clk); #1;
      s_penable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      s_psel = 1'b0; s_penable = 1'b0; tgt = -1;
      @(negedge clk);
      chk("rst_mid m_psel", m_psel, 0);
      chk("rst_mid m_penable", m_penable, 0);
      chk("rst_mid s_pready", s_pready, 0);
      stale = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (s_pready || (m_psel != '0) || err_timeout) stale = 1;
      end
      chk("rst_mid stale", stale, 0);
      @(posedge clk); #1;
      xfer(32'h0000_1000, 0, 32'h0, 0, 32'h2468_ACE0, 0, "after_rst");

      for (int k = 0; k < 40; k++) begin
         a = $urandom;
         idx = $urandom_range(0, 7);
         a[15:12] = 4'(idx);
         w = $urandom_range(0, 9);
         if (w == 9) w = 1000;
         xfer(a, 1'($urandom), $urandom, w, $urandom,
              1'($urandom), $sformatf("rnd%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
